ex_ctl: RTL and testbench
=========================

Name: ex_ctl

Overview:
- Next-generation EX-stage control for the minicpu pipeline.
- Decodes the stage-3 instruction into ALU select, quick-compare select and immediate select, as the existing EX decode does.
- Adds a parametrised multiply/divide sequencer that tracks MULT/MULTU/DIV/DIVU latency and generates pipeline stalls for HI/LO hazards.
- Sits between the ID/EX pipeline register and the ALU, qc and hilo datapath blocks.

Parameters:
- ALUSEL_W, 8, width of ALUsel (one-hot `select_alu_*` codes from mips.h)
- QCSEL_W, 6, width of QCsel (`select_qc_*` codes)
- MUL_CYCLES, 4, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 32, busy cycles for DIV/DIVU (≥1)
- CNT_W, 6, counter width; must hold max(MUL_CYCLES, DIV_CYCLES)

Ports:
- clk, in, 1, pipeline clock
- reset_n, in, 1, asynchronous active-low reset
- I2, in, 32, stage-3 instruction
- I2valid, in, 1, I2 holds a live (non-squashed) instruction
- Hold, in, 1, downstream stall; the EX instruction does not advance
- ALUsel, out, ALUSEL_W, ALU operation select
- QCsel, out, QCSEL_W, quick-compare select
- UseImm, out, 1, select immediate as ALU target operand
- MDstart, out, 1, one-cycle pulse launching the mul/div unit
- MDop, out, 2, operation qualified by MDstart: I2 funct[1:0] (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
- MDbusy, out, 1, sequencer not IDLE
- MDdone, out, 1, one-cycle pulse: HI/LO write-back this cycle
- Stall, out, 1, freeze IF/ID/EX

Behaviour:
- **Decode path (combinational from I2, unchanged semantics).**
  - UseImm is 1 for loads, stores, ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI, and SPECIAL SLL/SRL/SRA.
  - ALUsel follows the op/funct table: add for ADD/ADDU/ADDI/ADDIU and all loads/stores; sub for SUB/SUBU; LUI uses or.
  - QCsel follows the branch table (BEQ/BNE/BLEZ/BGTZ, REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL).
  - Don't-care (`dc`) outputs are driven as all-zero so the bench can compare exactly.
  - Decode outputs are independent of I2valid.
- **HI/LO classes.**
  - mdop: SPECIAL with funct 0x18..0x1B.
  - hiuse: SPECIAL with funct MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
- **Sequencer FSM.** States IDLE, BUSY, DONE; cnt is CNT_W bits.
  - Reset (async, reset_n=0): state=IDLE, cnt=0. MDbusy, MDdone and MDstart read 0 immediately, regardless of clk.
  - IDLE: if I2valid & mdop & !Hold:
    - MDstart=1 combinationally this cycle.
    - At the edge: cnt ← MUL_CYCLES when funct[1]=0, else DIV_CYCLES; state ← BUSY.
  - BUSY: cnt decrements each cycle. When cnt==1, the next state is DONE.
  - DONE: MDdone=1 for exactly one cycle, then IDLE.
  - Timing: an op issued in cycle t is BUSY for cycles t+1..t+LAT, DONE at t+LAT+1, IDLE at t+LAT+2.
  - MDbusy=1 in BUSY and DONE.
- **Stall.**
  - Stall = I2valid & (mdop | hiuse) & (state != IDLE).
  - A dependent instruction therefore issues in the first IDLE cycle, i.e. the cycle after MDdone.
  - Non-HI/LO instructions never stall and flow freely while the sequencer is BUSY.
  - MDstart is never asserted while Stall=1 or Hold=1.
- **Hold.** Hold=1 in IDLE with a pending mdop suppresses MDstart; the op launches the first cycle Hold=0. Hold has no effect on a running count.
- **Squash.** I2valid=0 suppresses MDstart and Stall; a running operation is never aborted.
- **Reset mid-operation.** The sequencer returns to IDLE and the result is discarded (MDdone is never pulsed).
- **No-op issue.** No issue takes place in a DONE cycle, even for an independent MULT.

Test Plan:
- Reset: reset_n=0 with I2=MULT (op 0, funct 0x18), I2valid=1 → MDstart=0, MDbusy=0, Stall=0. Release reset → MDstart=1 in the same cycle.
- Decode sweep: ADDI (op 0x08) → UseImm=1, ALUsel=select_alu_add. SPECIAL SUBU (funct 0x23) → UseImm=0, ALUsel=select_alu_sub. BNE (op 0x05) → QCsel=select_qc_ne. Undefined op 0x3F → ALUsel=0, QCsel=0.
- MULT then MFLO, MUL_CYCLES=4: MULT issued at t → MDop=00, BUSY t+1..t+4, MDdone at t+5. MFLO arriving at t+1 sees Stall=1 for t+1..t+5 and Stall=0 at t+6.
- DIVU, DIV_CYCLES=32: issue at t → MDop=11, MDdone exactly at t+33. Interleaved ADDU instructions at t+1..t+10 → Stall=0 throughout.
- Hold and squash: MULTU with Hold=1 for 3 cycles → no MDstart; MDstart in the cycle Hold drops. MULT with I2valid=0 → no MDstart, state stays IDLE.
- Reset mid-op: pulse reset_n low at t+10 of a DIV → state IDLE immediately, MDdone never asserted. A following MFHI → Stall=0.

Source files
------------

// File: rtl/ex_ctl.sv
// ex_ctl: minicpu EX-stage decode plus HI/LO multiply/divide sequencer.
// Decode is combinational on I2; the sequencer launches mul/div ops and owns HI/LO stalls.
module ex_ctl #(
  parameter int ALUSEL_W   = 8,
  parameter int QCSEL_W    = 6,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         I2,
  input  logic                I2valid,
  input  logic                Hold,
  output logic [ALUSEL_W-1:0] ALUsel,
  output logic [QCSEL_W-1:0]  QCsel,
  output logic                UseImm,
  output logic                MDstart,
  output logic [1:0]          MDop,
  output logic                MDbusy,
  output logic                MDdone,
  output logic                Stall
);

  localparam logic [ALUSEL_W-1:0] ALU_ADD  = ALUSEL_W'(1 << 0);
  localparam logic [ALUSEL_W-1:0] ALU_SUB  = ALUSEL_W'(1 << 1);
  localparam logic [ALUSEL_W-1:0] ALU_AND  = ALUSEL_W'(1 << 2);
  localparam logic [ALUSEL_W-1:0] ALU_OR   = ALUSEL_W'(1 << 3);
  localparam logic [ALUSEL_W-1:0] ALU_XOR  = ALUSEL_W'(1 << 4);
  localparam logic [ALUSEL_W-1:0] ALU_NOR  = ALUSEL_W'(1 << 5);
  localparam logic [ALUSEL_W-1:0] ALU_SLT  = ALUSEL_W'(1 << 6);
  localparam logic [ALUSEL_W-1:0] ALU_SLTU = ALUSEL_W'(1 << 7);

  localparam logic [QCSEL_W-1:0] QC_EQ  = QCSEL_W'(1 << 0);
  localparam logic [QCSEL_W-1:0] QC_NE  = QCSEL_W'(1 << 1);
  localparam logic [QCSEL_W-1:0] QC_LEZ = QCSEL_W'(1 << 2);
  localparam logic [QCSEL_W-1:0] QC_GTZ = QCSEL_W'(1 << 3);
  localparam logic [QCSEL_W-1:0] QC_LTZ = QCSEL_W'(1 << 4);
  localparam logic [QCSEL_W-1:0] QC_GEZ = QCSEL_W'(1 << 5);

  localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic       is_sp, is_ri, is_br, is_imm, is_ls;
  logic       mdop, hiuse, issue;
  logic       unused_bits;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign op = I2[31:26];
  assign fn = I2[5:0];
  assign rt = I2[20:16];
  assign unused_bits = ^{I2[25:21], I2[15:6]};

  assign is_sp  = op == 6'h00;
  assign is_ri  = op == 6'h01;
  assign is_br  = op[5:2] == 4'b0001;
  assign is_imm = op[5:3] == 3'b001;
  assign is_ls  = op[5:4] == 2'b10;

  // Shifts carry shamt in the immediate field and bypass the ALU select.
  always_comb begin
    ALUsel = '0;
    QCsel  = '0;
    UseImm = 1'b0;
    unique case (1'b1)
      is_sp: begin
        case (fn)
          6'h00, 6'h02, 6'h03: UseImm = 1'b1;
          6'h20, 6'h21:        ALUsel = ALU_ADD;
          6'h22, 6'h23:        ALUsel = ALU_SUB;
          6'h24:               ALUsel = ALU_AND;
          6'h25:               ALUsel = ALU_OR;
          6'h26:               ALUsel = ALU_XOR;
          6'h27:               ALUsel = ALU_NOR;
          6'h2a:               ALUsel = ALU_SLT;
          6'h2b:               ALUsel = ALU_SLTU;
          default: ;
        endcase
      end
      is_ri: begin
        if (rt[3:1] == 3'b000)
          QCsel = rt[0] ? QC_GEZ : QC_LTZ;
      end
      is_br: begin
        case (op[1:0])
          2'b00: QCsel = QC_EQ;
          2'b01: QCsel = QC_NE;
          2'b10: QCsel = QC_LEZ;
          2'b11: QCsel = QC_GTZ;
        endcase
      end
      is_imm: begin
        UseImm = 1'b1;
        case (op[2:0])
          3'd0, 3'd1: ALUsel = ALU_ADD;
          3'd2:       ALUsel = ALU_SLT;
          3'd3:       ALUsel = ALU_SLTU;
          3'd4:       ALUsel = ALU_AND;
          3'd5:       ALUsel = ALU_OR;
          3'd6:       ALUsel = ALU_XOR;
          3'd7:       ALUsel = ALU_OR;
        endcase
      end
      is_ls: begin
        UseImm = 1'b1;
        ALUsel = ALU_ADD;
      end
      default: ;
    endcase
  end

  assign mdop  = is_sp & (fn[5:2] == 4'b0110);
  assign hiuse = is_sp & (fn[5:2] == 4'b0100);
  // reset_n gates the launch so MDstart is quiet while reset is held.
  assign issue = reset_n & I2valid & mdop & ~Hold & (state_q == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    MDdone  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = BUSY;
          cnt_d   = fn[1] ? DIV_LAT : MUL_LAT;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1))
          state_d = DONE;
      end
      DONE: begin
        MDdone  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign MDstart = issue;
  assign MDop    = fn[1:0];
  assign MDbusy  = state_q != IDLE;
  assign Stall   = I2valid & (mdop | hiuse) & (state_q != IDLE);

endmodule

// File: tb/tb_ex_ctl.sv
// tb_ex_ctl: directed stimulus for ex_ctl; expectations queued by the driver,
// checked by a negedge monitor, MDdone timing checked against a done-cycle queue.
module tb_ex_ctl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] I2 = '0;
  logic        I2valid = 1'b0;
  logic        Hold = 1'b0;
  logic [7:0]  ALUsel;
  logic [5:0]  QCsel;
  logic        UseImm, MDstart, MDbusy, MDdone, Stall;
  logic [1:0]  MDop;
  logic [20:0] obs;

  always #5 clk = ~clk;

  ex_ctl dut (
    .clk(clk), .reset_n(reset_n), .I2(I2), .I2valid(I2valid), .Hold(Hold),
    .ALUsel(ALUsel), .QCsel(QCsel), .UseImm(UseImm), .MDstart(MDstart),
    .MDop(MDop), .MDbusy(MDbusy), .MDdone(MDdone), .Stall(Stall)
  );

  assign obs = {ALUsel, QCsel, UseImm, MDstart, MDop, MDbusy, MDdone, Stall};

  localparam logic [20:0] M_DEC = 21'h1FFFC0;
  localparam logic [20:0] M_CTL = 21'h000027;
  localparam logic [20:0] M_OP  = 21'h000018;

  localparam logic [31:0] MULT  = 32'h0000_0018;
  localparam logic [31:0] MULTU = 32'h0000_0019;
  localparam logic [31:0] DIV   = 32'h0000_001A;
  localparam logic [31:0] DIVU  = 32'h0000_001B;
  localparam logic [31:0] MFHI  = 32'h0000_0010;
  localparam logic [31:0] MFLO  = 32'h0000_0012;
  localparam logic [31:0] ADDU  = 32'h0000_0021;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  typedef struct {
    string       nm;
    int          cyc;
    logic [20:0] e;
    logic [20:0] m;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] dv_i [9] = '{32'h2000_0000, 32'h0000_0023, 32'h1400_0000,
                           32'hFC00_0000, 32'h3C00_0000, 32'h8C00_0000,
                           32'h0000_0140, 32'h0411_0000, 32'h0000_002A};
  logic [7:0]  dv_a [9] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h08, 8'h01,
                           8'h00, 8'h00, 8'h40};
  logic [5:0]  dv_q [9] = '{6'h00, 6'h00, 6'h02, 6'h00, 6'h00, 6'h00,
                           6'h00, 6'h20, 6'h00};
  logic        dv_u [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                           1'b1, 1'b0, 1'b0};
  string       dv_n [9] = '{"addi", "subu", "bne", "op3f", "lui", "lw",
                           "sll", "bgezal", "slt"};

  function automatic logic [20:0] dec(input logic [7:0] a,
                                      input logic [5:0] q,
                                      input logic i);
    return {a, q, i, 6'b0};
  endfunction

  function automatic logic [20:0] ctl(input logic st, input logic [1:0] op,
                                      input logic b, input logic d,
                                      input logic s);
    return {15'b0, st, op, b, d, s};
  endfunction

  task automatic drv(input logic [31:0] i, input logic v, input logic h);
    @(posedge clk);
    #1;
    I2 = i;
    I2valid = v;
    Hold = h;
  endtask

  task automatic chk(input string nm, input logic [20:0] e,
                     input logic [20:0] m);
    exp_t r;
    r.nm = nm;
    r.cyc = cyc;
    r.e = e;
    r.m = m;
    exp_q.push_back(r);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t r;
    int   w;
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      n_cmp++;
      if (r.cyc != cyc || (obs & r.m) != (r.e & r.m)) begin
        n_bad++;
        $display("FAIL %s cyc=%0d/%0d got=%h want=%h", r.nm, cyc, r.cyc,
                 obs & r.m, r.e & r.m);
      end
    end
    if (MDdone === 1'b1) begin
      n_cmp++;
      if (done_q.size() == 0) begin
        n_bad++;
        $display("FAIL mddone_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        w = done_q.pop_front();
        if (w != cyc) begin
          n_bad++;
          $display("FAIL mddone_cycle got=%0d want=%0d", cyc, w);
        end
      end
    end
  end

  initial begin
    int t;
    reset_n = 1'b0;
    I2 = MULT;
    I2valid = 1'b1;

    for (int k = 0; k < 2; k++) begin
      drv(MULT, 1'b1, 1'b0);
      chk("reset_quiet", ctl(0, 2'b00, 0, 0, 0), M_CTL);
    end

    @(posedge clk);
    #1;
    reset_n = 1'b1;
    t = cyc;
    chk("rel_start", ctl(1, 2'b00, 0, 0, 0), M_CTL | M_OP);
    done_q.push_back(t + 5);
    for (int k = 1; k <= 6; k++) begin
      drv(MFLO, 1'b1, 1'b0);
      chk($sformatf("mflo_t%0d", k),
          ctl(0, 2'b00, k <= 5, k == 5, k <= 5), M_CTL);
    end

    for (int k = 0; k < 9; k++) begin
      drv(dv_i[k], k[0], 1'b0);
      chk(dv_n[k], dec(dv_a[k], dv_q[k], dv_u[k]), M_DEC);
    end
    drv(32'h2000_0000, 1'b0, 1'b0);
    chk("addi_squashed", dec(8'h01, 6'h00, 1'b1), M_DEC);

    drv(DIVU, 1'b1, 1'b0);
    t = cyc;
    chk("divu_start", ctl(1, 2'b11, 0, 0, 0), M_CTL | M_OP);
    done_q.push_back(t + 33);
    for (int k = 1; k <= 10; k++) begin
      drv(ADDU, 1'b1, 1'b0);
      chk("divu_addu", ctl(0, 2'b00, 1, 0, 0), M_CTL);
    end
    for (int k = 11; k <= 32; k++) begin
      drv(NOP, 1'b1, 1'b0);
      chk("divu_busy", ctl(0, 2'b00, 1, 0, 0), M_CTL);
    end
    drv(MULT, 1'b1, 1'b0);
    chk("done_no_issue", ctl(0, 2'b00, 1, 1, 1), M_CTL);
    drv(MULT, 1'b1, 1'b0);
    chk("issue_after_done", ctl(1, 2'b00, 0, 0, 0), M_CTL | M_OP);
    done_q.push_back(cyc + 5);
    for (int k = 1; k <= 6; k++) begin
      drv(NOP, 1'b1, 1'b0);
      chk("mult2_run", ctl(0, 2'b00, k <= 5, k == 5, 0), M_CTL);
    end

    for (int k = 0; k < 3; k++) begin
      drv(MULTU, 1'b1, 1'b1);
      chk("hold_nostart", ctl(0, 2'b00, 0, 0, 0), M_CTL);
    end
    drv(MULTU, 1'b1, 1'b0);
    chk("hold_drop_start", ctl(1, 2'b01, 0, 0, 0), M_CTL | M_OP);
    done_q.push_back(cyc + 5);
    for (int k = 1; k <= 6; k++) begin
      drv(NOP, 1'b1, k <= 3);
      chk("hold_running", ctl(0, 2'b00, k <= 5, k == 5, 0), M_CTL);
    end
    for (int k = 0; k < 2; k++) begin
      drv(MULT, 1'b0, 1'b0);
      chk("squash_nostart", ctl(0, 2'b00, 0, 0, 0), M_CTL);
    end
    drv(NOP, 1'b1, 1'b0);
    chk("squash_idle", ctl(0, 2'b00, 0, 0, 0), M_CTL);

    drv(DIV, 1'b1, 1'b0);
    chk("div_start", ctl(1, 2'b10, 0, 0, 0), M_CTL | M_OP);
    for (int k = 1; k <= 9; k++) begin
      drv(NOP, 1'b1, 1'b0);
      chk("div_busy", ctl(0, 2'b00, 1, 0, 0), M_CTL);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    I2 = NOP;
    chk("midrst_idle", ctl(0, 2'b00, 0, 0, 0), M_CTL);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    I2 = MFHI;
    chk("mfhi_nostall", ctl(0, 2'b00, 0, 0, 0), M_CTL);
    for (int k = 0; k < 30; k++) begin
      drv(NOP, 1'b1, 1'b0);
      chk("no_done", ctl(0, 2'b00, 0, 0, 0), M_CTL);
    end

    drv(NOP, 1'b1, 1'b0);
    drv(NOP, 1'b1, 1'b0);
    n_cmp++;
    if (done_q.size() != 0) begin
      n_bad++;
      $display("FAIL mddone_missing got=%0d pending want=0", done_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
